// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with a two-state data-memory request controller.
// Define EXMEM_LLSC_EN to add the LL/SC link register and SC status word.
module ex_mem_latch #(
   parameter int ADDR_W = 26
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        enable,
   input  logic        flush,
   input  logic [31:0] aluout_in,
   input  logic [31:0] rdat2_in,
   input  logic [31:0] pcp4_in,
   input  logic [31:0] extImm_in,
   input  logic [5:0]  op_in,
   input  logic        dREN_in,
   input  logic        dWEN_in,
   input  logic        RegWr_in,
   input  logic        halt_in,
   input  logic        ll_in,
   input  logic        sc_in,
   input  logic [1:0]  MemToReg_in,
   input  logic [4:0]  wsel_in,
   input  logic        dhit,
   input  logic [31:0] dmemload,
   output logic        dmemREN,
   output logic        dmemWEN,
   output logic [31:0] dmemaddr,
   output logic [31:0] dmemstore,
   output logic [31:0] aluout_out,
   output logic [31:0] pcp4_out,
   output logic [31:0] extImm_out,
   output logic [5:0]  op_out,
   output logic [1:0]  MemToReg_out,
   output logic        RegWr_out,
   output logic [4:0]  wsel_out,
   output logic        halt_out,
   output logic [31:0] dmemload_out,
   output logic [31:0] sc_result_out,
   output logic        mem_stall
);

   localparam int W_UNUSED_ADDR_W = ADDR_W;

   typedef enum logic {S_IDLE, S_ACCESS} state_t;

   state_t      r_state;
   logic [31:0] r_aluout, r_pcp4, r_extimm, r_rdat2, r_dmemload;
   logic [5:0]  r_op;
   logic [1:0]  r_memtoreg;
   logic [4:0]  r_wsel;
   logic        r_regwr, r_halt, r_dren, r_dwen;
   logic        w_done, w_capture, w_start, w_sc_block;

   assign mem_stall = (r_state == S_ACCESS) && !dhit;
   assign w_done    = (r_state == S_ACCESS) && dhit;
   assign w_capture = enable && !mem_stall;
   // A halted pipeline (or one halting on this capture) never starts a new access.
   assign w_start   = !flush && (dREN_in || dWEN_in) && !(r_halt || halt_in) && !w_sc_block;

   assign dmemREN       = (r_state == S_ACCESS) && r_dren;
   assign dmemWEN       = (r_state == S_ACCESS) && r_dwen;
   assign dmemaddr      = r_aluout;
   assign dmemstore     = r_rdat2;
   assign aluout_out    = r_aluout;
   assign pcp4_out      = r_pcp4;
   assign extImm_out    = r_extimm;
   assign op_out        = r_op;
   assign MemToReg_out  = r_memtoreg;
   assign RegWr_out     = r_regwr;
   assign wsel_out      = r_wsel;
   assign halt_out      = r_halt;
   assign dmemload_out  = r_dmemload;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state    <= S_IDLE;
         r_aluout   <= '0;
         r_pcp4     <= '0;
         r_extimm   <= '0;
         r_rdat2    <= '0;
         r_op       <= '0;
         r_memtoreg <= '0;
         r_regwr    <= 1'b0;
         r_wsel     <= '0;
         r_halt     <= 1'b0;
         r_dren     <= 1'b0;
         r_dwen     <= 1'b0;
         r_dmemload <= '0;
      end else begin
         if (w_done && r_dren)
            r_dmemload <= dmemload;
         if (w_capture) begin
            r_state    <= w_start ? S_ACCESS : S_IDLE;
            r_aluout   <= flush ? '0 : aluout_in;
            r_pcp4     <= flush ? '0 : pcp4_in;
            r_extimm   <= flush ? '0 : extImm_in;
            r_rdat2    <= flush ? '0 : rdat2_in;
            r_op       <= flush ? '0 : op_in;
            r_memtoreg <= flush ? '0 : MemToReg_in;
            r_regwr    <= !flush && RegWr_in;
            r_wsel     <= flush ? '0 : wsel_in;
            r_halt     <= r_halt || (!flush && halt_in);
            r_dren     <= !flush && dREN_in;
            r_dwen     <= !flush && dWEN_in;
         end else if (w_done) begin
            r_state <= S_IDLE;
         end
      end
   end

`ifdef EXMEM_LLSC_EN
   logic        r_ll, r_sc, r_link_v;
   logic [29:0] r_link_a;
   logic [31:0] r_sc_result;
   logic        w_link_v, w_sc_ok;
   logic [29:0] w_link_a;

   // Link state as it stands after any access completing on this edge, so an
   // SC captured on the same edge sees the LL or store that just finished.
   always_comb begin
      w_link_v = r_link_v;
      w_link_a = r_link_a;
      if (w_done && r_dren && r_ll) begin
         w_link_v = 1'b1;
         w_link_a = r_aluout[31:2];
      end else if (w_done && r_dwen && !r_sc && (r_aluout[31:2] == r_link_a)) begin
         w_link_v = 1'b0;
      end
   end

   assign w_sc_ok       = w_link_v && (w_link_a == aluout_in[31:2]);
   assign w_sc_block    = sc_in && !w_sc_ok;
   assign sc_result_out = r_sc_result;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_ll        <= 1'b0;
         r_sc        <= 1'b0;
         r_link_v    <= 1'b0;
         r_link_a    <= '0;
         r_sc_result <= '0;
      end else begin
         r_link_v <= w_link_v;
         r_link_a <= w_link_a;
         if (w_capture) begin
            r_ll <= !flush && ll_in;
            r_sc <= !flush && sc_in;
            if (!flush && sc_in) begin
               r_sc_result <= {31'd0, w_sc_ok};
               if (w_sc_ok)
                  r_link_v <= 1'b0;
            end
         end
      end
   end
`else
   logic w_unused_llsc;
   assign w_unused_llsc = ll_in ^ sc_in;
   assign w_sc_block    = 1'b0;
   assign sc_result_out = 32'd1;
`endif

endmodule

// File: tb/tb_ex_mem_latch.sv
// Directed bench for ex_mem_latch: spec-level model checked every cycle plus literal spot checks.
module tb_ex_mem_latch;

   logic        CLK = 1'b0, nRST = 1'b0, enable = 1'b0, flush = 1'b0;
   logic [31:0] aluout_in = '0, rdat2_in = '0, pcp4_in = '0, extImm_in = '0;
   logic [5:0]  op_in = '0;
   logic        dREN_in = 1'b0, dWEN_in = 1'b0, RegWr_in = 1'b0, halt_in = 1'b0;
   logic        ll_in = 1'b0, sc_in = 1'b0, dhit = 1'b0;
   logic [1:0]  MemToReg_in = '0;
   logic [4:0]  wsel_in = '0;
   logic [31:0] dmemload = '0;

   logic        dmemREN, dmemWEN, RegWr_out, halt_out, mem_stall;
   logic [31:0] dmemaddr, dmemstore, aluout_out, pcp4_out, extImm_out;
   logic [31:0] dmemload_out, sc_result_out;
   logic [5:0]  op_out;
   logic [1:0]  MemToReg_out;
   logic [4:0]  wsel_out;

   always #5 CLK = ~CLK;

   ex_mem_latch #(.ADDR_W(26)) dut (
      .CLK(CLK), .nRST(nRST), .enable(enable), .flush(flush),
      .aluout_in(aluout_in), .rdat2_in(rdat2_in), .pcp4_in(pcp4_in), .extImm_in(extImm_in),
      .op_in(op_in), .dREN_in(dREN_in), .dWEN_in(dWEN_in), .RegWr_in(RegWr_in),
      .halt_in(halt_in), .ll_in(ll_in), .sc_in(sc_in), .MemToReg_in(MemToReg_in),
      .wsel_in(wsel_in), .dhit(dhit), .dmemload(dmemload),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
      .aluout_out(aluout_out), .pcp4_out(pcp4_out), .extImm_out(extImm_out),
      .op_out(op_out), .MemToReg_out(MemToReg_out), .RegWr_out(RegWr_out),
      .wsel_out(wsel_out), .halt_out(halt_out), .dmemload_out(dmemload_out),
      .sc_result_out(sc_result_out), .mem_stall(mem_stall)
   );

   int checks = 0, failures = 0;
   bit cmp_on = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [31:0] alu, pcp4, ext, st;
      logic [5:0]  op;
      logic [1:0]  m2r;
      logic        rw;
      logic [4:0]  wsel;
      logic        halt, dren, dwen, ll, sc;
   } rec_t;

   rec_t        m = '0, m_nx = '0;
   bit          m_pend = 1'b0, m_stall = 1'b0, m_scfail = 1'b0, m_lv = 1'b0;
   logic [29:0] m_la = '0;
   logic [31:0] m_load = '0, m_scr = '0;

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         m = '0; m_pend = 1'b0; m_load = '0; m_lv = 1'b0; m_la = '0; m_scr = '0;
      end else begin
         m_stall = m_pend && !dhit;
         if (m_pend && dhit) begin
            if (m.dren) m_load = dmemload;
`ifdef EXMEM_LLSC_EN
            if (m.dren && m.ll) begin
               m_lv = 1'b1; m_la = m.alu[31:2];
            end else if (m.dwen && !m.sc && m.alu[31:2] == m_la) begin
               m_lv = 1'b0;
            end
`endif
            m_pend = 1'b0;
         end
         if (enable && !m_stall) begin
            m_nx = flush ? '0 : rec_t'{aluout_in, pcp4_in, extImm_in, rdat2_in, op_in, MemToReg_in,
                                       RegWr_in, wsel_in, halt_in, dREN_in, dWEN_in, ll_in, sc_in};
            m_scfail = 1'b0;
`ifdef EXMEM_LLSC_EN
            if (!flush && sc_in) begin
               if (m_lv && m_la == aluout_in[31:2]) begin
                  m_scr = 32'd1; m_lv = 1'b0;
               end else begin
                  m_scr = 32'd0; m_scfail = 1'b1;
               end
            end
`endif
            m_nx.halt = m.halt | m_nx.halt;
            m = m_nx;
            m_pend = (m.dren || m.dwen) && !m.halt && !m_scfail;
         end
      end
   end

   always @(negedge CLK) begin
      if (cmp_on) begin
         chk("aluout_out",   aluout_out,            m.alu);
         chk("pcp4_out",     pcp4_out,              m.pcp4);
         chk("extImm_out",   extImm_out,            m.ext);
         chk("op_out",       32'(op_out),           32'(m.op));
         chk("MemToReg_out", 32'(MemToReg_out),     32'(m.m2r));
         chk("RegWr_out",    32'(RegWr_out),        32'(m.rw));
         chk("wsel_out",     32'(wsel_out),         32'(m.wsel));
         chk("halt_out",     32'(halt_out),         32'(m.halt));
         chk("dmemaddr",     dmemaddr,              m.alu);
         chk("dmemstore",    dmemstore,             m.st);
         chk("dmemREN",      32'(dmemREN),          32'(m_pend && m.dren));
         chk("dmemWEN",      32'(dmemWEN),          32'(m_pend && m.dwen));
         chk("mem_stall",    32'(mem_stall),        32'(m_pend && !dhit));
         chk("dmemload_out", dmemload_out,          m_load);
`ifdef EXMEM_LLSC_EN
         chk("sc_result_out", sc_result_out,        m_scr);
`else
         chk("sc_result_out", sc_result_out,        32'd1);
`endif
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge CLK); #1;
   endtask

   task automatic set_op(input logic [31:0] alu, input logic ren, input logic wen,
                         input logic rw, input logic [4:0] ws, input logic [31:0] st);
      aluout_in   = alu;
      pcp4_in     = alu ^ 32'h1000_0004;
      extImm_in   = ~alu;
      rdat2_in    = st;
      dREN_in     = ren;
      dWEN_in     = wen;
      RegWr_in    = rw;
      wsel_in     = ws;
      MemToReg_in = ren ? 2'd1 : 2'd0;
      op_in       = ren ? 6'h23 : (wen ? 6'h2b : 6'h00);
   endtask

   int stalls;

   initial begin
      repeat (2) tick();
      chk("rst_aluout",   aluout_out, 32'h0);
      chk("rst_halt",     32'(halt_out), 32'h0);
      chk("rst_dmemREN",  32'(dmemREN), 32'h0);
      chk("rst_stall",    32'(mem_stall), 32'h0);
      chk("rst_dmemload", dmemload_out, 32'h0);
      nRST = 1'b1;
      cmp_on = 1'b1;

      // plain ALU op
      set_op(32'h1234, 0, 0, 1, 5'd5, 32'h0);
      enable = 1'b1;
      tick();
      chk("alu_aluout", aluout_out, 32'h1234);
      chk("alu_regwr",  32'(RegWr_out), 32'h1);
      chk("alu_wsel",   32'(wsel_out), 32'h5);
      chk("alu_stall",  32'(mem_stall), 32'h0);

      // load, dhit after three stall cycles
      set_op(32'h80, 1, 0, 1, 5'd3, 32'h0);
      tick();
      set_op(32'h55, 0, 0, 1, 5'd7, 32'h0);
      chk("ld_dmemREN",  32'(dmemREN), 32'h1);
      chk("ld_dmemaddr", dmemaddr, 32'h80);
      stalls = 0;
      for (int i = 0; i < 3; i++) begin
         if (mem_stall) stalls++;
         tick();
      end
      chk("ld_stall_cycles", 32'(stalls), 32'd3);
      chk("ld_hold_aluout", aluout_out, 32'h80);
      dmemload = 32'hDEADBEEF;
      dhit = 1'b1;
      #1;
      chk("ld_hit_stall", 32'(mem_stall), 32'h0);
      tick();
      dhit = 1'b0;
      chk("ld_dmemload_out", dmemload_out, 32'hDEADBEEF);
      chk("ld_next_aluout",  aluout_out, 32'h55);
      chk("ld_done_REN",     32'(dmemREN), 32'h0);

      // store with flush arriving mid-access
      set_op(32'h40, 0, 1, 1, 5'd9, 32'hCAFE);
      tick();
      chk("st_dmemWEN",   32'(dmemWEN), 32'h1);
      chk("st_dmemstore", dmemstore, 32'hCAFE);
      flush = 1'b1;
      tick();
      chk("st_flush_WEN", 32'(dmemWEN), 32'h1);
      chk("st_flush_alu", aluout_out, 32'h40);
      dhit = 1'b1;
      tick();
      dhit = 1'b0;
      flush = 1'b0;
      chk("bubble_regwr",  32'(RegWr_out), 32'h0);
      chk("bubble_alu",    aluout_out, 32'h0);
      chk("bubble_WEN",    32'(dmemWEN), 32'h0);
      chk("st_keep_load",  dmemload_out, 32'hDEADBEEF);

      // load with dhit in its first ACCESS cycle
      set_op(32'h200, 1, 0, 1, 5'd4, 32'h0);
      tick();
      set_op(32'h66, 0, 0, 1, 5'd1, 32'h0);
      dmemload = 32'h11112222;
      dhit = 1'b1;
      #1;
      chk("fast_stall", 32'(mem_stall), 32'h0);
      chk("fast_REN",   32'(dmemREN), 32'h1);
      tick();
      dhit = 1'b0;
      chk("fast_load", dmemload_out, 32'h11112222);
      chk("fast_next", aluout_out, 32'h66);

      // asynchronous reset in the middle of an access
      set_op(32'h300, 1, 0, 1, 5'd2, 32'h0);
      tick();
      chk("ar_REN_before", 32'(dmemREN), 32'h1);
      #2 nRST = 1'b0;
      #1;
      chk("ar_REN",      32'(dmemREN), 32'h0);
      chk("ar_stall",    32'(mem_stall), 32'h0);
      chk("ar_aluout",   aluout_out, 32'h0);
      chk("ar_dmemload", dmemload_out, 32'h0);
      chk("ar_regwr",    32'(RegWr_out), 32'h0);
      tick();
      nRST = 1'b1;
      set_op(32'h7, 0, 0, 1, 5'd1, 32'h0);
      tick();
      chk("ar_idle_stall", 32'(mem_stall), 32'h0);
      chk("ar_idle_alu",   aluout_out, 32'h7);

      // sticky halt blocks new accesses
      set_op(32'h10, 0, 0, 0, 5'd0, 32'h0);
      halt_in = 1'b1;
      tick();
      halt_in = 1'b0;
      chk("halt_set", 32'(halt_out), 32'h1);
      set_op(32'h400, 1, 0, 1, 5'd6, 32'h0);
      tick();
      chk("halt_noREN", 32'(dmemREN), 32'h0);
      chk("halt_stall", 32'(mem_stall), 32'h0);
      chk("halt_alu",   aluout_out, 32'h400);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("halt_sticky", 32'(halt_out), 32'h1);

      // LL / SC sequence from a clean reset
      nRST = 1'b0;
      tick();
      nRST = 1'b1;
      set_op(32'h100, 1, 0, 1, 5'd8, 32'h0);
      ll_in = 1'b1;
      tick();
      ll_in = 1'b0;
      set_op(32'h0, 0, 0, 0, 5'd0, 32'h0);
      dmemload = 32'h0000AAAA;
      dhit = 1'b1;
      tick();
      dhit = 1'b0;
      chk("ll_load", dmemload_out, 32'h0000AAAA);
      set_op(32'h100, 0, 1, 1, 5'd8, 32'h5555);
      sc_in = 1'b1;
      tick();
      sc_in = 1'b0;
      set_op(32'h0, 0, 0, 0, 5'd0, 32'h0);
      chk("sc1_WEN",    32'(dmemWEN), 32'h1);
      chk("sc1_result", sc_result_out, 32'h1);
      dhit = 1'b1;
      tick();
      dhit = 1'b0;
      set_op(32'h100, 0, 1, 1, 5'd8, 32'h6666);
      sc_in = 1'b1;
      tick();
      sc_in = 1'b0;
      set_op(32'h0, 0, 0, 0, 5'd0, 32'h0);
`ifdef EXMEM_LLSC_EN
      chk("sc2_WEN",    32'(dmemWEN), 32'h0);
      chk("sc2_stall",  32'(mem_stall), 32'h0);
      chk("sc2_result", sc_result_out, 32'h0);
`else
      chk("sc2_WEN",    32'(dmemWEN), 32'h1);
      chk("sc2_result", sc_result_out, 32'h1);
      dhit = 1'b1;
      tick();
      dhit = 1'b0;
`endif
      repeat (2) tick();
      cmp_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_mem_latch.md
# ex_mem_latch

Execute/Memory pipeline register and data-memory request controller. It sits between the execute stage (ALU, fed by the ID/EX latch) and the MEM/WB latch. It captures the execute-stage results and the memory/writeback controls. For loads and stores it holds the data-memory request until `dhit`, stalling the upstream pipeline meanwhile. Optionally it implements the LL/SC link register.

## Interface
Parameters:
- `ADDR_W`, 26: width of the j-type address field (codebase-wide).

Ports (widths from `cpu_types_pkg`; word = 32):
- `CLK`  in  1  clock; all state updates on rising edge.
- `nRST`  in  1  asynchronous active-low reset.
- `enable`  in  1  advance the register (from hazard unit).
- `flush`  in  1  load a bubble instead of inputs.
- `aluout_in`  in  32  ALU result; also the memory address.
- `rdat2_in`  in  32  store data.
- `pcp4_in`, `extImm_in`  in  32  PC+4 and extended immediate, passed through.
- `op_in`  in  6  opcode.
- `dREN_in`, `dWEN_in`, `RegWr_in`, `halt_in`, `ll_in`, `sc_in`  in  1  each, control.
- `MemToReg_in`  in  2  writeback select.
- `wsel_in`  in  5  destination register.
- `dhit`  in  1  data memory done.
- `dmemload`  in  32  data memory read data.
- `dmemREN`, `dmemWEN`  out  1  data memory request.
- `dmemaddr`, `dmemstore`  out  32  request address and data.
- `aluout_out`, `pcp4_out`, `extImm_out`, `op_out`, `MemToReg_out`, `RegWr_out`, `wsel_out`, `halt_out`  out  as inputs  registered copies.
- `dmemload_out`  out  32  captured load data.
- `sc_result_out`  out  32  SC status word.
- `mem_stall`  out  1  memory access in progress; stall upstream.

## Operation
- **Reset:** every registered output is 0, and the FSM is in IDLE.
- **Capture:** when `enable && !mem_stall`, all `*_out` registers load their `*_in` values.
- **Flush:** if `flush` is also set, a bubble is loaded instead. A bubble has all control bits 0, `wsel` = 0 and data 0.
- **Priority:** `flush` outranks input capture. `mem_stall` outranks both.
- **FSM IDLE:**
  - On capture, go to ACCESS if the captured `dREN_in | dWEN_in` is 1 (and not suppressed by LL/SC).
  - Otherwise remain in IDLE.
- **FSM ACCESS:**
  - Drive `dmemREN`/`dmemWEN` from the latched `dREN`/`dWEN`, `dmemaddr` = `aluout_out`, `dmemstore` = latched `rdat2`.
  - `mem_stall = !dhit`.
  - On `dhit`, `dmemload_out <= dmemload` (reads only) and return to IDLE. That same edge may also capture the next instruction if `enable` is set.
- **IDLE outputs:** `dmemREN` = `dmemWEN` = 0; `dmemaddr` and `dmemstore` still reflect the latched values.
- **Flush during ACCESS:** ignored until `dhit`. A started access always completes.
- **Halt:** `halt_out` is sticky. Once 1 it stays 1 until `nRST`. While it is 1, no new access is started.
- **Asynchronous reset mid-access:** the request is dropped immediately, and the FSM and outputs clear.

## Timing
- Pipeline register latency: 1 cycle.
- Non-memory instructions: zero stall.
- Memory instructions: `mem_stall` is high from the cycle after capture until the cycle in which `dhit` arrives. It is combinational in `dhit`.
- `dhit` in the first ACCESS cycle gives zero stall cycles.
- `dmemload_out` is valid from the edge that ends ACCESS until the next read completes.

## Configuration
- **`EXMEM_LLSC_EN` defined:**
  - The link register holds {valid, addr[31:2]}.
  - An LL read completing on `dhit` sets valid and the address.
  - An SC with valid and a matching address performs the write, sets `sc_result_out` = 1 and clears valid.
  - An SC that fails issues no memory request (no ACCESS, no stall) and sets `sc_result_out` = 0.
  - Any completed plain store to the linked address clears valid.
  - Reset clears valid.
- **`EXMEM_LLSC_EN` undefined:**
  - `ll_in` and `sc_in` are ignored; LL behaves as a plain load and SC as a plain store.
  - `sc_result_out` is tied to 32'd1.
  - No link register is present.

## Test plan
- ALU op: `aluout_in`=0x1234, `RegWr_in`=1, `wsel_in`=5, `enable`=1 -> next edge `aluout_out`=0x1234, `RegWr_out`=1, `wsel_out`=5, `mem_stall`=0.
- Load with `dhit` after 3 cycles: `dREN_in`=1, `aluout_in`=0x80 -> `dmemREN`=1, `dmemaddr`=0x80 and `mem_stall`=1 for 3 cycles; then with `dmemload`=0xDEADBEEF and `dhit`, `dmemload_out`=0xDEADBEEF and `mem_stall`=0.
- `flush`=1 mid-ACCESS -> request held until `dhit`; the next capture with `flush` produces a bubble (`RegWr_out`=0, `dREN_out`=0).
- `nRST` pulsed low during ACCESS -> `dmemREN`, `dmemWEN`, `mem_stall` and all outputs 0 immediately; FSM in IDLE.
- `halt_in`=1 captured, then a load presented -> `halt_out` stays 1, no `dmemREN` asserted.
- With `EXMEM_LLSC_EN`: LL 0x100 completes, then SC 0x100 -> write issued, `sc_result_out`=1. A second SC 0x100 -> no request, `sc_result_out`=0.
